alu_issue_ctrl: RTL and testbench

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

---
 rtl/alu_pkg.sv | 49 ++++
 rtl/alu_funct_decode.sv | 44 ++++
 rtl/alu_issue_ctrl.sv | 116 +++++++++++
 tb/tb_alu_issue_ctrl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for the EX-stage ALU issue controller: aluop/funct codes,
// ALU operation and result-mux selects, and the multiply FSM state type.
package alu_pkg;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_ILL   = 2'b11;

    localparam logic [5:0] FUNCT_SLL   = 6'd0;
    localparam logic [5:0] FUNCT_JR    = 6'd8;
    localparam logic [5:0] FUNCT_MFHI  = 6'd16;
    localparam logic [5:0] FUNCT_MFLO  = 6'd18;
    localparam logic [5:0] FUNCT_MULTU = 6'd25;
    localparam logic [5:0] FUNCT_ADD   = 6'd32;
    localparam logic [5:0] FUNCT_SUB   = 6'd34;
    localparam logic [5:0] FUNCT_AND   = 6'd36;
    localparam logic [5:0] FUNCT_OR    = 6'd37;
    localparam logic [5:0] FUNCT_SLT   = 6'd42;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    localparam logic [1:0] MUX_ALU = 2'b00;
    localparam logic [1:0] MUX_HI  = 2'b01;
    localparam logic [1:0] MUX_LO  = 2'b10;
    localparam logic [1:0] MUX_SHT = 2'b11;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StMulRun  = 2'd1,
        StMulDone = 2'd2
    } issue_state_e;

    // True for every R-type funct this datapath implements.
    function automatic logic funct_known(input logic [5:0] f);
        logic known;
        case (f)
            FUNCT_SLL, FUNCT_JR, FUNCT_MFHI, FUNCT_MFLO, FUNCT_MULTU,
            FUNCT_ADD, FUNCT_SUB, FUNCT_AND, FUNCT_OR, FUNCT_SLT: known = 1'b1;
            default:                                              known = 1'b0;
        endcase
        return known;
    endfunction

endpackage

// File: rtl/alu_funct_decode.sv
// Combinational ALU control decode: aluop/funct to ALU operation, shifter
// select and result-mux select. Idle (valid low) decodes as a plain ADD.
module alu_funct_decode
    import alu_pkg::*;
(
    input  logic       valid_i,
    input  logic [1:0] aluop_i,
    input  logic [5:0] funct_i,
    output logic [2:0] operation_o,
    output logic       sht_sel_o,
    output logic [1:0] mux_sel_o
);

    always_comb begin
        operation_o = OP_ADD;
        sht_sel_o   = 1'b0;
        mux_sel_o   = MUX_ALU;
        if (valid_i) begin
            case (aluop_i)
                ALUOP_ADD: operation_o = OP_ADD;
                ALUOP_SUB: operation_o = OP_SUB;
                ALUOP_RTYPE: begin
                    // JR, MULTU, MFHI/MFLO, SLL and unknown functs keep the ADD default.
                    case (funct_i)
                        FUNCT_AND:  operation_o = OP_AND;
                        FUNCT_OR:   operation_o = OP_OR;
                        FUNCT_ADD:  operation_o = OP_ADD;
                        FUNCT_SUB:  operation_o = OP_SUB;
                        FUNCT_SLT:  operation_o = OP_SLT;
                        FUNCT_SLL: begin
                            sht_sel_o = 1'b1;
                            mux_sel_o = MUX_SHT;
                        end
                        FUNCT_MFHI: mux_sel_o = MUX_HI;
                        FUNCT_MFLO: mux_sel_o = MUX_LO;
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// EX-stage ALU issue control: funct decode plus the MULTU stall/run FSM.
// Define ALU_ISSUE_ILLEGAL_TRAP_EN to add the sticky illegal-instruction flag.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       valid,
    input  logic [1:0] aluop,
    input  logic [5:0] funct,
    input  logic       flush,
    output logic [2:0] operation,
    output logic       SignaltoMULTU,
    output logic       SignaltoSHT,
    output logic [1:0] SignaltoMUX,
    output logic       stall,
    output logic       mul_done,
    output logic       illegal
);

    localparam int unsigned CntW = (MULT_CYCLES > 1) ? $clog2(MULT_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(MULT_CYCLES - 1);

    issue_state_e    state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            multu_req;

    alu_funct_decode u_decode (
        .valid_i     (valid),
        .aluop_i     (aluop),
        .funct_i     (funct),
        .operation_o (operation),
        .sht_sel_o   (SignaltoSHT),
        .mux_sel_o   (SignaltoMUX)
    );

    assign multu_req = valid && (aluop == ALUOP_RTYPE) && (funct == FUNCT_MULTU);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        stall         = 1'b0;
        SignaltoMULTU = 1'b0;
        mul_done      = 1'b0;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                // Stall asserts in the accept cycle itself so dataA/dataB hold from here on.
                if (multu_req && !flush && !rst) begin
                    stall   = 1'b1;
                    state_d = StMulRun;
                end
            end
            StMulRun: begin
                SignaltoMULTU = 1'b1;
                stall         = 1'b1;
                if (flush) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (cnt_q == CntLast) begin
                    state_d = StMulDone;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StMulDone: begin
                // Pipeline is released this cycle; inputs are ignored so a held MULTU
                // cannot retrigger until IDLE.
                mul_done = 1'b1;
                state_d  = StIdle;
                cnt_d    = '0;
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
    logic illegal_q, illegal_d;

    always_comb begin
        illegal_d = illegal_q;
        if (valid && (((aluop == ALUOP_RTYPE) && !funct_known(funct)) || (aluop == ALUOP_ILL))) begin
            illegal_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= illegal_d;
        end
    end

    assign illegal = illegal_q;
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: decode table, MULTU/flush/reset
// sequences, and randomized traffic against an elapsed-cycle reference model.
module tb_alu_issue_ctrl;

    localparam int M = 32;

`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
    localparam bit TrapEn = 1'b1;
`else
    localparam bit TrapEn = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       valid;
    logic [1:0] aluop;
    logic [5:0] funct;
    logic       flush;
    logic [2:0] operation;
    logic       multu;
    logic       sht;
    logic [1:0] mux;
    logic       stall;
    logic       mul_done;
    logic       illegal;

    alu_issue_ctrl #(.MULT_CYCLES(M)) dut (
        .clk           (clk),
        .rst           (rst),
        .valid         (valid),
        .aluop         (aluop),
        .funct         (funct),
        .flush         (flush),
        .operation     (operation),
        .SignaltoMULTU (multu),
        .SignaltoSHT   (sht),
        .SignaltoMUX   (mux),
        .stall         (stall),
        .mul_done      (mul_done),
        .illegal       (illegal)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    // Model: k = cycles elapsed since a MULTU was accepted (0 = idle).
    int k        = 0;
    bit ill_m    = 1'b0;

    typedef struct {
        logic       v;
        logic [1:0] a;
        logic [5:0] f;
        logic       fl;
        logic [2:0] op;
        logic       sh;
        logic [1:0] mx;
        logic       st;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit ref_legal(input logic [5:0] f);
        int codes[10] = '{0, 8, 16, 18, 25, 32, 34, 36, 37, 42};
        foreach (codes[i]) if (f == codes[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void ref_decode(input logic v, input logic [1:0] a, input logic [5:0] f,
                                       output logic [2:0] op, output logic s,
                                       output logic [1:0] mx);
        op = 3'd2;
        s  = 1'b0;
        mx = 2'd0;
        if (!v) return;
        if (a == 2'd1) op = 3'd6;
        else if (a == 2'd2) begin
            if (f == 6'd36) op = 3'd0;
            else if (f == 6'd37) op = 3'd1;
            else if (f == 6'd34) op = 3'd6;
            else if (f == 6'd42) op = 3'd7;
            if (f == 6'd0) begin
                s  = 1'b1;
                mx = 2'd3;
            end else if (f == 6'd16) mx = 2'd1;
            else if (f == 6'd18) mx = 2'd2;
        end
    endfunction

    function automatic bit accept_now();
        return (k == 0) && !rst && valid && aluop == 2'd2 && funct == 6'd25 && !flush;
    endfunction

    task automatic check_now(input string tag);
        logic [2:0] eop;
        logic       es;
        logic [1:0] emx;
        ref_decode(valid, aluop, funct, eop, es, emx);
        chk({tag, ".operation"}, operation, eop);
        chk({tag, ".sht"}, sht, es);
        chk({tag, ".mux"}, mux, emx);
        chk({tag, ".stall"}, stall, rst ? 0 : (k == 0 ? accept_now() : (k <= M)));
        chk({tag, ".multu"}, multu, !rst && k >= 1 && k <= M);
        chk({tag, ".mul_done"}, mul_done, !rst && k == M + 1);
        chk({tag, ".illegal"}, illegal, TrapEn ? ill_m : 1'b0);
    endtask

    // Called between edges (at negedge): compute next model state, cross the posedge.
    task automatic advance();
        int k_n;
        bit ill_n;
        if (k == 0) k_n = accept_now() ? 1 : 0;
        else if (k <= M) k_n = flush ? 0 : k + 1;
        else k_n = 0;
        ill_n = ill_m || (valid && ((aluop == 2'd2 && !ref_legal(funct)) || aluop == 2'd3));
        if (rst) begin
            k_n   = 0;
            ill_n = 1'b0;
        end
        @(posedge clk);
        k     = k_n;
        ill_m = ill_n;
        #1;
    endtask

    task automatic step(input string tag);
        @(negedge clk);
        check_now(tag);
        advance();
    endtask

    task automatic idle_inputs();
        valid = 1'b0;
        aluop = 2'd0;
        funct = 6'd0;
        flush = 1'b0;
    endtask

    initial begin
        int st_cnt, mu_cnt, done_cnt, done_at;
        int r;
        int pool[10] = '{0, 8, 16, 18, 25, 32, 34, 36, 37, 42};

        tbl[0]  = '{1'b1, 2'd2, 6'd42, 1'b0, 3'd7, 1'b0, 2'd0, 1'b0};
        tbl[1]  = '{1'b1, 2'd2, 6'd0,  1'b0, 3'd2, 1'b1, 2'd3, 1'b0};
        tbl[2]  = '{1'b1, 2'd2, 6'd16, 1'b0, 3'd2, 1'b0, 2'd1, 1'b0};
        tbl[3]  = '{1'b1, 2'd2, 6'd18, 1'b0, 3'd2, 1'b0, 2'd2, 1'b0};
        tbl[4]  = '{1'b1, 2'd1, 6'd0,  1'b0, 3'd6, 1'b0, 2'd0, 1'b0};
        tbl[5]  = '{1'b1, 2'd0, 6'd36, 1'b0, 3'd2, 1'b0, 2'd0, 1'b0};
        tbl[6]  = '{1'b1, 2'd2, 6'd36, 1'b0, 3'd0, 1'b0, 2'd0, 1'b0};
        tbl[7]  = '{1'b1, 2'd2, 6'd37, 1'b0, 3'd1, 1'b0, 2'd0, 1'b0};
        tbl[8]  = '{1'b1, 2'd2, 6'd34, 1'b0, 3'd6, 1'b0, 2'd0, 1'b0};
        tbl[9]  = '{1'b1, 2'd2, 6'd8,  1'b0, 3'd2, 1'b0, 2'd0, 1'b0};
        tbl[10] = '{1'b0, 2'd2, 6'd0,  1'b0, 3'd2, 1'b0, 2'd0, 1'b0};
        tbl[11] = '{1'b1, 2'd2, 6'd25, 1'b1, 3'd2, 1'b0, 2'd0, 1'b0};
        tbl[12] = '{1'b1, 2'd2, 6'd32, 1'b0, 3'd2, 1'b0, 2'd0, 1'b0};

        rst = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        step("reset");
        valid = 1'b1; aluop = 2'd2; funct = 6'd25;
        step("reset_multu_req");
        idle_inputs();
        rst = 1'b0;

        // Decode table
        foreach (tbl[i]) begin
            valid = tbl[i].v; aluop = tbl[i].a; funct = tbl[i].f; flush = tbl[i].fl;
            @(negedge clk);
            chk($sformatf("tbl%0d.operation", i), operation, tbl[i].op);
            chk($sformatf("tbl%0d.sht", i), sht, tbl[i].sh);
            chk($sformatf("tbl%0d.mux", i), mux, tbl[i].mx);
            chk($sformatf("tbl%0d.stall", i), stall, tbl[i].st);
            advance();
        end
        idle_inputs();
        step("post_table");

        // Full MULTU with the request held through MUL_DONE (must not retrigger)
        st_cnt = 0; mu_cnt = 0; done_cnt = 0; done_at = -1;
        valid = 1'b1; aluop = 2'd2; funct = 6'd25;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (stall) st_cnt++;
            if (multu) mu_cnt++;
            if (mul_done) begin
                done_cnt++;
                if (done_at < 0) done_at = c;
            end
            if (c == 0) chk("multu.accept_stall", stall, 1);
            if (c == 0) chk("multu.accept_no_run", multu, 0);
            check_now("multu");
            advance();
            if (c == 33) valid = 1'b0;
        end
        chk("multu.stall_cycles", 8'(st_cnt), 8'(M + 1));
        chk("multu.run_cycles", 8'(mu_cnt), 8'(M));
        chk("multu.done_count", 8'(done_cnt), 1);
        chk("multu.done_cycle", 8'(done_at), 8'(M + 1));
        idle_inputs();

        // Flush in MUL_RUN
        done_cnt = 0;
        valid = 1'b1; aluop = 2'd2; funct = 6'd25;
        for (int c = 0; c < 45; c++) begin
            @(negedge clk);
            if (mul_done) done_cnt++;
            if (c == 5) chk("flush.stall_in_flush_cycle", stall, 1);
            if (c == 6) chk("flush.stall_after", stall, 0);
            if (c == 6) chk("flush.multu_after", multu, 0);
            check_now("flush");
            advance();
            if (c == 0) valid = 1'b0;
            flush = (c == 4);
        end
        chk("flush.no_done", 8'(done_cnt), 0);
        idle_inputs();

        // Asynchronous reset mid-run
        done_cnt = 0;
        valid = 1'b1; aluop = 2'd2; funct = 6'd25;
        for (int c = 0; c < 10; c++) begin
            step("rst_mid_pre");
            if (c == 0) valid = 1'b0;
        end
        #2 rst = 1'b1;
        #1;
        chk("rst_mid.multu", multu, 0);
        chk("rst_mid.stall", stall, 0);
        chk("rst_mid.done", mul_done, 0);
        k = 0;
        ill_m = 1'b0;
        step("rst_mid_hold");
        rst = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (mul_done) done_cnt++;
            check_now("rst_mid_post");
            advance();
        end
        chk("rst_mid.no_done", 8'(done_cnt), 0);

        // Illegal funct: sticky until reset
        valid = 1'b1; aluop = 2'd2; funct = 6'd63;
        step("illegal_set");
        idle_inputs();
        @(negedge clk);
        chk("illegal.next_cycle", illegal, TrapEn);
        advance();
        repeat (3) step("illegal_hold");
        @(negedge clk);
        chk("illegal.held", illegal, TrapEn);
        rst = 1'b1;
        #1;
        chk("illegal.cleared_by_rst", illegal, 0);
        k = 0;
        ill_m = 1'b0;
        advance();
        rst = 1'b0;

        // Randomized traffic
        for (int c = 0; c < 2500; c++) begin
            valid = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 15);
            aluop = (r < 2) ? 2'd0 : (r < 4) ? 2'd1 : (r < 15) ? 2'd2 : 2'd3;
            r = $urandom_range(0, 10);
            funct = (r == 10) ? 6'($urandom) : 6'(pool[r]);
            flush = ($urandom_range(0, 19) == 0);
            step("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
